// File: rtl/led_status_pkg.sv
// Shared types and constants for led_status_uart_tx: FSM encodings, ASCII
// codes and the baud divisor helper.
package led_status_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} frame_state_t;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} ser_state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq_hz,
                                                      input int unsigned baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serialiser, 8N1 LSB first; 8E1 when LED_TX_PARITY_EN is
// defined. Accepts a byte with valid/ready, ready only while idle.
module uart_tx_byte
    import led_status_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       TXD
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    // The idle cycle that follows S_STOP is the final cycle of the stop bit,
    // so a queued byte can start with no gap between characters.
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);

    ser_state_t       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
`ifdef LED_TX_PARITY_EN
    logic             parity;
`endif

    assign ready = (state == S_IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            TXD      <= 1'b1;
`ifdef LED_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    TXD      <= 1'b1;
                    if (valid) begin
                        shreg <= data;
`ifdef LED_TX_PARITY_EN
                        parity <= ^data;
`endif
                        TXD   <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        TXD      <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef LED_TX_PARITY_EN
                            TXD   <= parity;
                            state <= S_PARITY;
`else
                            TXD   <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            TXD     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef LED_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        TXD      <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_cnt == STOP_LAST) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/led_status_uart_tx.sv
// Sends the LED word as ASCII '0'/'1' text plus CR LF whenever it changes;
// changes during a frame are coalesced. LED_TX_PARITY_EN selects 8E1 framing.
module led_status_uart_tx
    import led_status_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned NLEDS       = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [NLEDS-1:0] leds_i,
    output logic             TXD,
    output logic             busy
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int unsigned NCHARS       = NLEDS + 2;
    localparam int unsigned IDX_W        = $clog2(NCHARS + 1);

    if (CLKS_PER_BIT < 2) begin : g_baud_check
        $error("led_status_uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
    end

    frame_state_t     state;
    logic [NLEDS-1:0] sync1, sync2, last_sent, snapshot;
    logic             pending;
    logic [IDX_W-1:0] char_idx;
    logic [7:0]       ch;
    logic             changed, valid, ready;

    assign changed = (sync2 != last_sent);
    assign valid   = (state == SEND) && (char_idx != IDX_W'(NCHARS));

    always_comb begin
        ch = ASCII_LF;
        if (char_idx == IDX_W'(NLEDS)) ch = ASCII_CR;
        for (int unsigned k = 0; k < NLEDS; k++)
            if (char_idx == IDX_W'(k)) ch = ASCII_0 | {7'd0, snapshot[NLEDS-1-k]};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            sync1     <= '0;
            sync2     <= '0;
            last_sent <= '0;
            snapshot  <= '0;
            pending   <= 1'b0;
            char_idx  <= '0;
            busy      <= 1'b0;
        end else begin
            sync1 <= leds_i;
            sync2 <= sync1;
            if (state != IDLE && changed) pending <= 1'b1;
            case (state)
                IDLE: if (changed || pending) state <= LOAD;
                LOAD: begin
                    snapshot  <= sync2;
                    last_sent <= sync2;
                    pending   <= 1'b0;
                    char_idx  <= '0;
                    state     <= SEND;
                end
                SEND: begin
                    // Serialiser back in idle after the last handoff means the
                    // final stop bit is in its last cycle.
                    if (valid && ready) begin
                        char_idx <= char_idx + 1'b1;
                        busy     <= 1'b1;
                    end else if (ready && !valid) begin
                        busy  <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .CLK  (CLK),
        .RESET(RESET),
        .data (ch),
        .valid(valid),
        .ready(ready),
        .TXD  (TXD)
    );

endmodule

// File: tb/tb_led_status_uart_tx.sv
// Bench for led_status_uart_tx: frame-level reference model checked every
// cycle, a mid-bit UART decoder, directed scenarios and random LED changes.
`timescale 1ns/1ps
module tb_led_status_uart_tx;

    localparam int unsigned CLK_FREQ_HZ = 1000;
    localparam int unsigned BAUD        = 100;
    localparam int unsigned NLEDS       = 5;
    localparam int CPB = 10;
`ifdef LED_TX_PARITY_EN
    localparam int BPC = 11;
`else
    localparam int BPC = 10;
`endif
    localparam int NCH   = NLEDS + 2;
    localparam int FRAME = NCH * BPC * CPB;
    localparam int NEVER = 2147483647;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic [NLEDS-1:0] leds_i = '0;
    logic             TXD, busy;

    led_status_uart_tx #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD),
        .NLEDS      (NLEDS)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .leds_i(leds_i),
        .TXD   (TXD),
        .busy  (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int               n = 0;
    logic [NLEDS-1:0] m_s1, m_s2, m_last, m_snap;
    bit               m_pending;
    int               m_idle_from = 0, m_load_at = -1, m_start = -1000000;

    function automatic logic [7:0] char_of(input logic [NLEDS-1:0] v, input int k);
        if (k < NLEDS) return 8'h30 + {7'd0, v[NLEDS-1-k]};
        if (k == NLEDS) return 8'h0D;
        return 8'h0A;
    endfunction

    function automatic logic frame_bit(input logic [NLEDS-1:0] v, input int idx);
        logic [7:0] c;
        int b;
        c = char_of(v, idx / BPC);
        b = idx % BPC;
        if (b == 0) return 1'b0;
        if (b <= 8) return c[b-1];
        if (BPC == 11 && b == 9) return ^c;
        return 1'b1;
    endfunction

    // A frame's first start bit appears two edges after the LOAD edge; the
    // next idle evaluation comes one GAP cycle after the frame ends.
    always @(posedge CLK) begin
        n++;
        if (RESET) begin
            m_s1 = '0; m_s2 = '0; m_last = '0; m_snap = '0;
            m_pending = 0; m_idle_from = 0; m_load_at = -1; m_start = -1000000;
        end else begin
            m_s2 = m_s1;
            m_s1 = leds_i;
            if (n == m_load_at) begin
                m_snap = m_s2; m_last = m_s2; m_pending = 0;
                m_start = n + 2;
                m_idle_from = m_start + FRAME + 1;
            end else if (n >= m_idle_from) begin
                if (m_s2 != m_last || m_pending) begin
                    m_load_at = n + 1;
                    m_idle_from = NEVER;
                end
            end else if (m_s2 != m_last) begin
                m_pending = 1;
            end
        end
    end

    always @(negedge CLK) begin
        logic exp_txd, exp_busy;
        if (!RESET) begin
            if (n >= m_start && n < m_start + FRAME) begin
                exp_busy = 1'b1;
                exp_txd  = frame_bit(m_snap, (n - m_start) / CPB);
            end else begin
                exp_busy = 1'b0;
                exp_txd  = 1'b1;
            end
            checks++;
            if (TXD !== exp_txd) begin
                errors++;
                $display("FAIL txd at edge %0d: got %b expected %b", n, TXD, exp_txd);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy at edge %0d: got %b expected %b", n, busy, exp_busy);
            end
        end
    end

    // ---------------- mid-bit UART decoder and busy span meter ----------------
    int         ncyc = 0, d_t0 = 0, frame_err = 0;
    bit         d_active = 0;
    logic [7:0] d_byte;
    logic       d_par;
    logic [7:0] rx_q[$];
    int         rx_start[$];
    logic       rx_par[$];
    int         busy_run = 0, last_busy_run = 0;

    always @(negedge CLK) begin
        int off, b;
        ncyc++;
        if (RESET) begin
            d_active = 0;
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                last_busy_run = busy_run;
                busy_run = 0;
            end
            if (!d_active) begin
                if (TXD == 1'b0) begin
                    d_active = 1; d_t0 = ncyc; d_byte = '0; d_par = 1'b0;
                end
            end else begin
                off = ncyc - d_t0;
                if (off % CPB == CPB / 2) begin
                    b = off / CPB;
                    if (b == 0) begin
                        if (TXD !== 1'b0) frame_err++;
                    end else if (b <= 8) begin
                        d_byte[b-1] = TXD;
                    end else if (b == BPC - 1) begin
                        if (TXD !== 1'b1) frame_err++;
                        rx_q.push_back(d_byte);
                        rx_start.push_back(d_t0);
                        rx_par.push_back(d_par);
                        d_active = 0;
                    end else begin
                        d_par = TXD;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int k);
        repeat (k) @(negedge CLK);
    endtask

    task automatic wait_quiet(input int need, input int budget);
        int q, t;
        q = 0; t = 0;
        while (q < need && t < budget) begin
            @(negedge CLK);
            t++;
            if (!busy && TXD) q++; else q = 0;
        end
        check("wait_quiet_in_time", (q >= need), 1);
    endtask

    task automatic wait_bytes(input int k, input int budget);
        int t;
        t = 0;
        while (rx_q.size() < k && t < budget) begin
            @(negedge CLK);
            t++;
        end
        check("bytes_in_time", (rx_q.size() >= k), 1);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_start.delete();
        rx_par.delete();
        frame_err = 0;
    endtask

    logic [7:0] exp_single [7]  = '{8'h31, 8'h30, 8'h31, 8'h31, 8'h30, 8'h0D, 8'h0A};
    logic [7:0] exp_coal   [14] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A,
                                    8'h30, 8'h30, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A};
    logic [7:0] exp_ones   [7]  = '{8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A};

    initial begin
        int bad, lat;
        RESET = 1'b1;
        leds_i = '0;
        tick(5);
        RESET = 1'b0;

        // Idle after reset with an all-zero LED word.
        bad = 0;
        repeat (1000) begin
            @(negedge CLK);
            if (TXD !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_bad_cycles", bad, 0);
        check("idle_no_bytes", rx_q.size(), 0);

        // Single frame, latency and bit spacing.
        clear_rx();
        leds_i = 5'b10110;
        lat = 0;
        while (TXD !== 1'b0 && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check("first_start_latency", lat, 5);
        wait_bytes(7, 1500);
        wait_quiet(20, 1500);
        check("single_byte_count", rx_q.size(), 7);
        for (int i = 0; i < 7 && i < rx_q.size(); i++)
            check($sformatf("single_byte%0d", i), rx_q[i], exp_single[i]);
        for (int i = 1; i < 7 && i < rx_start.size(); i++)
            check($sformatf("start_spacing%0d", i), rx_start[i] - rx_start[i-1], BPC * CPB);
        check("single_busy_len", last_busy_run, FRAME);
        check("single_framing", frame_err, 0);

        // Coalescing: 00011 is overwritten by 00111 before the frame ends.
        clear_rx();
        leds_i = 5'b00001;
        tick(50);
        leds_i = 5'b00011;
        tick(100);
        leds_i = 5'b00111;
        wait_bytes(14, 3000);
        wait_quiet(50, 3000);
        check("coalesce_byte_count", rx_q.size(), 14);
        for (int i = 0; i < 14 && i < rx_q.size(); i++)
            check($sformatf("coalesce_byte%0d", i), rx_q[i], exp_coal[i]);

        // Reset in the middle of a frame.
        clear_rx();
        leds_i = 5'b11111;
        lat = 0;
        while (TXD !== 1'b0 && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check("ones_latency", lat, 5);
        repeat (250) @(posedge CLK);
        #1;
        check("busy_before_reset", busy, 1);
        #1;
        RESET = 1'b1;
        #1;
        check("reset_async_txd", TXD, 1);
        check("reset_async_busy", busy, 0);
        clear_rx();
        bad = 0;
        repeat (5) begin
            @(negedge CLK);
            if (TXD !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("reset_hold_quiet", bad, 0);
        RESET = 1'b0;
        wait_bytes(7, 1500);
        wait_quiet(50, 1500);
        check("after_reset_byte_count", rx_q.size(), 7);
        for (int i = 0; i < 7 && i < rx_q.size(); i++)
            check($sformatf("after_reset_byte%0d", i), rx_q[i], exp_ones[i]);
        check("after_reset_busy_len", last_busy_run, FRAME);

        // Random LED traffic against the per-cycle model.
        clear_rx();
        for (int i = 0; i < 40; i++) begin
            leds_i = 5'($urandom_range(0, 31));
            tick(int'($urandom_range(1, 900)));
        end
        wait_quiet(50, 5000);
        check("random_whole_frames", rx_q.size() % NCH, 0);
        check("random_framing", frame_err, 0);

`ifdef LED_TX_PARITY_EN
        // Even parity on '0' and '1' characters.
        leds_i = 5'b00000;
        wait_quiet(50, 3000);
        clear_rx();
        leds_i = 5'b00001;
        wait_bytes(7, 2000);
        wait_quiet(20, 2000);
        if (rx_q.size() >= 7) begin
            check("parity_char0", rx_par[0], 0);
            check("parity_char4", rx_par[4], 1);
            check("parity_char4_data", rx_q[4], 8'h31);
        end
        check("parity_busy_len", last_busy_run, 770);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/led_status_uart_tx.md
Name: led_status_uart_tx

Overview:
Downstream consumer of the SOC LED pattern stage; drives the currently unused TXD pin.
Watches the 5-bit LED word and, whenever it changes, transmits it over UART 8N1 as ASCII text: one '0'/'1' per LED (MSB first), then CR, LF.
Changes arriving during a frame are coalesced, so only the latest pattern is sent next.
Runs on the raw board clock, so bit timing is independent of the Clockworks gearbox.

Parameters:
CLK_FREQ_HZ, 12000000, frequency of CLK in Hz.
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer division, truncated); elaboration error if < 2.
NLEDS, 5, width of the LED word; characters per frame = NLEDS + 2.

Ports:
CLK  input  1  board clock; all state on posedge.
RESET  input  1  asynchronous, active-high reset; clears all state immediately.
leds_i  input  NLEDS  LED word from the pattern stage (slow-clock domain, quasi-static).
TXD  output  1  UART serial out; idle high.
busy  output  1  high from first start bit to end of last stop bit of a frame.

Behaviour:
- Reset values: TXD=1, busy=0, sync regs=0, last_sent=0, pending=0, FSM=IDLE, counters=0.
- Input path: leds_i passes through a 2-flop synchroniser (sync1, sync2); the comparison uses sync2.
- Change detect: changed = (sync2 != last_sent), evaluated every CLK.
- Because last_sent resets to 0, a non-zero pattern present after reset produces one frame.
- Frame FSM (IDLE, LOAD, SEND, GAP):
  - IDLE -> LOAD when changed=1 or pending=1.
  - LOAD, one cycle: snapshot <= sync2; last_sent <= sync2; pending <= 0; char_idx <= 0.
  - SEND: issue chars in order. char k (0..NLEDS-1) = 8'h30 + snapshot[NLEDS-1-k]; char NLEDS = 8'h0D; char NLEDS+1 = 8'h0A.
  - Each char is handed to the byte serialiser with valid/ready.
  - After the last char's stop bit completes -> GAP.
  - GAP, one cycle -> IDLE.
- Coalescing: while not IDLE, if sync2 differs from last_sent, set pending=1. Intermediate values are discarded. The value snapshotted at the next LOAD is sync2 at that cycle.
- Byte serialiser, 8N1 LSB first:
  - Start bit 0, 8 data bits, stop bit 1; each bit is held exactly CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps.
  - ready=1 only in the serialiser's idle state.
  - A valid&&ready handshake drives TXD=0 on the next cycle.
  - Back-to-back chars: the next start bit immediately follows the previous stop bit, with no idle gap inside a frame.
- Latency: leds_i change -> TXD falling edge = 2 (sync) + 1 (detect/IDLE) + 1 (LOAD) + 1 (handshake) = 5 CLK cycles.
- Frame length: (NLEDS+2) × 10 × CLKS_PER_BIT cycles; busy is high for exactly this span.
- TXD is registered and glitch-free.
- Reset mid-frame: TXD returns to 1 asynchronously, the frame is abandoned, and the next frame starts from scratch.
- Simultaneous change and frame end (GAP cycle): pending is set; the frame starts after GAP -> IDLE -> LOAD.

Optional Feature:
LED_TX_PARITY_EN
- Defined: 8E1. An even parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit. Frame length becomes (NLEDS+2) × 11 × CLKS_PER_BIT.
- Undefined: 8N1 as above, with no parity logic instantiated.

Decomposition:
- Package led_status_pkg:
  - Frame FSM enum (IDLE, LOAD, SEND, GAP).
  - Serialiser state enum (S_IDLE, S_START, S_DATA, S_PARITY, S_STOP).
  - ASCII constants ASCII_0=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - Function computing CLKS_PER_BIT.
- Sub-module uart_tx_byte (CLK, RESET, data[7:0], valid, ready, TXD). It owns the baud counter, the bit counter and the parity option. The top level owns the synchroniser, change detect, coalescing and character sequencing.

Test Plan:
- Reset/idle: hold RESET, then release with leds_i=0 (CLK_FREQ_HZ=1000, BAUD=100 → 10 clk/bit) -> TXD stays 1 and busy stays 0 for 1000 cycles.
- Single frame: leds_i 0→5'b10110 -> TXD falls 5 cycles later; decoded bytes are 31 30 31 31 30 0D 0A; busy is high exactly 700 cycles.
- Bit timing: the same frame decoded by a sampling UART model at mid-bit (cycle 5 of 10) gives all bits correct, and every start bit is exactly 100 cycles after the previous one.
- Coalescing: during a frame, drive 00001, 00011, 00111 in sequence -> exactly two frames, first "00001\r\n", then "00111\r\n"; no frame for 00011.
- Reset mid-frame: assert RESET at cycle 250 of a frame -> TXD=1 in the same cycle, no further bits; after release with unchanged leds_i=11111, one full frame "11111\r\n" is sent.
- Parity (LED_TX_PARITY_EN defined): leds_i=5'b00001 -> byte '1'=8'h31 carries parity bit 1 and '0'=8'h30 carries parity bit 0; frame length is 770 cycles.
